grad_dir_quant: RTL and testbench

- Parametrised, pipelined gradient-orientation quantiser for the SIFT orientation-assignment and descriptor stages.
- Input: signed pixel gradient (dx, dy). Output: orientation bin index in 0..NBINS-1.
- Uses octant folding, a generated arctangent ROM and a bin-scaling stage, with a valid/ready handshake and a pass-through tag.
- Replaces the fixed 8-bit-address, 5-bit direction LUTs. One instance serves both 36-bin (orientation) and 8-bin (descriptor) paths.

---
 rtl/grad_dir_pkg.sv | 56 +++++
 rtl/octant_atan_rom.sv | 31 +++
 rtl/grad_dir_quant.sv | 198 +++++++++++++++++++
 tb/tb_grad_dir_quant.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_dir_pkg.sv
// Shared definitions for the gradient-orientation quantiser: quadrant
// encoding, octant angle constants, the arctangent ROM generator and a
// clog2 helper.
package grad_dir_pkg;

  // Quadrant of the raw gradient, counter-clockwise from +x.
  typedef enum logic [1:0] {
    QD_PP = 2'd0,  // dx >= 0, dy >= 0
    QD_NP = 2'd1,  // dx <  0, dy >= 0
    QD_NN = 2'd2,  // dx <  0, dy <  0
    QD_PN = 2'd3   // dx >= 0, dy <  0
  } quad_e;

  localparam real PI = 3.14159265358979323846;

  // One octant (45 degrees) is F = 2^af angle units.
  function automatic int ang_2f(input int af);
    return 2 << af;
  endfunction

  function automatic int ang_4f(input int af);
    return 4 << af;
  endfunction

  function automatic int ang_6f(input int af);
    return 6 << af;
  endfunction

  function automatic int ang_8f(input int af);
    return 8 << af;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // ROM entry for address {mxq[q-2:0], mnq}; the implied mxq MSB is 1.
  // Result is round(F * atan(mnq/mxq) * 4/pi), clamped to F for the
  // unreachable addresses where mnq > mxq.
  function automatic int atan_rom_entry(input int addr, input int q, input int af);
    int  mxq;
    int  mnq;
    int  t;
    real a;
    mxq = (1 << (q - 1)) | ((addr >> q) & ((1 << (q - 1)) - 1));
    mnq = addr & ((1 << q) - 1);
    a   = $atan(real'(mnq) / real'(mxq)) * 4.0 / PI * real'(1 << af);
    t   = $rtoi(a + 0.5);
    if (t > (1 << af)) t = 1 << af;
    return t;
  endfunction

endpackage

// File: rtl/octant_atan_rom.sv
// Registered first-octant arctangent ROM. The address is the normalised
// {max mantissa without its leading one, min mantissa}; the output is the
// angle inside the octant in units of 45/2^AF degrees (0..2^AF).
module octant_atan_rom
  import grad_dir_pkg::*;
#(
  parameter int Q  = 5,
  parameter int AF = 5
) (
  input  logic            clk,
  input  logic            en,
  input  logic [2*Q-2:0]  addr,
  output logic [AF:0]     t
);

  localparam int DEPTH = 1 << (2*Q - 1);
  localparam int TW1   = AF + 1;

  logic [AF:0] rom_mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int ENT = atan_rom_entry(i, Q, AF);
    assign rom_mem[i] = TW1'(ENT);
  end

  // Registered read; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) t <= rom_mem[addr];
  end

endmodule

// File: rtl/grad_dir_quant.sv
// Pipelined gradient-orientation quantiser: folds (dx, dy) into the first
// octant, normalises the magnitudes, looks up the octant angle in a ROM,
// unfolds to a full-circle angle and scales it to NBINS bins.
// Optional feature macro: GDQ_ROUND_EN (round to nearest bin centre);
// when undefined the bin is the floor of angle * NBINS / 360 degrees.
module grad_dir_quant
  import grad_dir_pkg::*;
#(
  parameter int GW    = 9,
  parameter int NBINS = 36,
  parameter int AF    = 5,
  parameter int Q     = 5,
  parameter int OW    = 6,
  parameter int TW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [GW-1:0] in_dx,
  input  logic signed [GW-1:0] in_dy,
  input  logic [TW-1:0]        in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_bin,
  output logic                 out_zero,
  output logic [TW-1:0]        out_tag
);

  localparam int AW  = AF + 3;          // full-circle angle width (8F units)
  localparam int AW1 = AW + 1;          // headroom for unfolding before the wrap
  localparam int AL  = 2*Q - 1;         // ROM address width
  localparam int PW  = AF + 4 + OW;     // product width plus rounding carry
  localparam int LZW = clog2(GW + 1);   // leading-zero count width
`ifdef GDQ_ROUND_EN
  localparam int RND = 1 << (AF + 2);
`else
  localparam int RND = 0;
`endif

  localparam logic [AW:0] A2F = AW1'(ang_2f(AF));
  localparam logic [AW:0] A4F = AW1'(ang_4f(AF));
  localparam logic [AW:0] A6F = AW1'(ang_6f(AF));
  localparam logic [AW:0] A8F = AW1'(ang_8f(AF));

  // Magnitude as GW-bit unsigned; -2^(GW-1) maps to 2^(GW-1) without overflow.
  function automatic logic [GW-1:0] abs_u(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    u = v;
    return u[GW-1] ? (~u + GW'(1)) : u;
  endfunction

  function automatic logic [LZW-1:0] lzc(input logic [GW-1:0] v);
    logic [LZW-1:0] n;
    logic           seen;
    n    = '0;
    seen = 1'b0;
    for (int i = GW - 1; i >= 0; i--) begin
      if (!seen && !v[i]) n = n + LZW'(1);
      else seen = 1'b1;
    end
    return n;
  endfunction

  // Shift both magnitudes by the leading zeros of the larger one and keep
  // the top Q bits; the max mantissa's leading one is implied in the address.
  function automatic logic [AL-1:0] norm_addr(input logic [GW-1:0] mx,
                                               input logic [GW-1:0] mn);
    logic [GW-1:0]  mx_n;
    logic [GW-1:0]  mn_n;
    logic [LZW-1:0] lz;
    lz   = lzc(mx);
    mx_n = mx << lz;
    mn_n = mn << lz;
    return {mx_n[GW-2 -: Q-1], mn_n[GW-1 -: Q]};
  endfunction

  // Octant angle back to the full circle, wrapped modulo 8F.
  function automatic logic [AW-1:0] unfold(input quad_e qd, input logic s,
                                           input logic [AF:0] t);
    logic [AW:0] tt;
    logic [AW:0] th;
    tt = AW1'(t);
    case (qd)
      QD_PP:   th = s ? (A2F - tt) : tt;
      QD_NP:   th = s ? (A2F + tt) : (A4F - tt);
      QD_NN:   th = s ? (A6F - tt) : (A4F + tt);
      default: th = s ? (A6F + tt) : (A8F - tt);
    endcase
    return th[AW-1:0];
  endfunction

  // Angle to bin index at full product width; a rounded result of NBINS
  // (angle just below 360 degrees) wraps to bin 0.
  function automatic logic [OW-1:0] scale_bin(input logic [AW-1:0] th);
    logic [PW-1:0] p;
    logic [PW-1:0] b;
    p = PW'(th) * PW'(NBINS) + PW'(RND);
    b = p >> AW;
    if (b == PW'(NBINS)) b = '0;
    return b[OW-1:0];
  endfunction

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic                 vld_p1, vld_p2, vld_p3;
  quad_e                qd_p1, qd_p2, qd_p3;
  logic                 swp_p1, swp_p2, swp_p3;
  logic                 zero_p1, zero_p2, zero_p3;
  logic [GW-1:0]        mx_p1, mn_p1;
  logic [TW-1:0]        tag_p1, tag_p2, tag_p3;
  logic [AL-1:0]        addr_p2;
  logic [AF:0]          t_p3;

  logic [GW-1:0]        ax, ay;
  logic                 swp_s1;
  quad_e                qd_s1;
  logic [OW-1:0]        bin_s4;

  // S1 combinational: magnitudes, quadrant and octant swap decision.
  always_comb begin
    ax     = abs_u(in_dx);
    ay     = abs_u(in_dy);
    swp_s1 = (ay > ax);
    case ({in_dx[GW-1], in_dy[GW-1]})
      2'b00:   qd_s1 = QD_PP;
      2'b10:   qd_s1 = QD_NP;
      2'b11:   qd_s1 = QD_NN;
      default: qd_s1 = QD_PN;
    endcase
  end

  // S4 combinational: unfold the octant angle and scale it to a bin.
  always_comb begin
    bin_s4 = zero_p3 ? '0 : scale_bin(unfold(qd_p3, swp_p3, t_p3));
  end

  // Stage valids and the output register; all hold on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
      out_bin   <= bin_s4;
      out_zero  <= zero_p3;
      out_tag   <= tag_p3;
    end
  end

  // S1 -> S2 -> S3 data registers (no reset: qualified by the valids).
  always_ff @(posedge clk) begin
    if (adv) begin
      // S1: fold
      qd_p1   <= qd_s1;
      swp_p1  <= swp_s1;
      mx_p1   <= swp_s1 ? ay : ax;
      mn_p1   <= swp_s1 ? ax : ay;
      zero_p1 <= (ax == '0) && (ay == '0);
      tag_p1  <= in_tag;
      // S2: normalise
      qd_p2   <= qd_p1;
      swp_p2  <= swp_p1;
      zero_p2 <= zero_p1;
      addr_p2 <= norm_addr(mx_p1, mn_p1);
      tag_p2  <= tag_p1;
      // S3: side band alongside the ROM read
      qd_p3   <= qd_p2;
      swp_p3  <= swp_p2;
      zero_p3 <= zero_p2;
      tag_p3  <= tag_p2;
    end
  end

  octant_atan_rom #(
    .Q  (Q),
    .AF (AF)
  ) u_rom (
    .clk  (clk),
    .en   (adv),
    .addr (addr_p2),
    .t    (t_p3)
  );

endmodule

// File: tb/tb_grad_dir_quant.sv
`timescale 1ns/1ps
module tb_grad_dir_quant;

  localparam int GW    = 9;
  localparam int NBINS = 36;
  localparam int AF    = 5;
  localparam int Q     = 5;
  localparam int OW    = 6;
  localparam int TW    = 8;
  localparam int F     = 1 << AF;
`ifdef GDQ_ROUND_EN
  localparam int RND   = 1 << (AF + 2);
  localparam bit RMODE = 1'b1;
`else
  localparam int RND   = 0;
  localparam bit RMODE = 1'b0;
`endif
  localparam real M_PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [GW-1:0] in_dx = '0;
  logic signed [GW-1:0] in_dy = '0;
  logic [TW-1:0]        in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [OW-1:0]        out_bin;
  logic                 out_zero;
  logic [TW-1:0]        out_tag;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int bin;
    bit zero;
    int tag;
  } exp_t;

  always #5 clk = ~clk;

  grad_dir_quant #(
    .GW(GW), .NBINS(NBINS), .AF(AF), .Q(Q), .OW(OW), .TW(TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dx     (in_dx),
    .in_dy     (in_dy),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  // Reference: angle in the first quadrant from the normalised mantissas,
  // mirrored into the right quadrant, then floor/round scaled to bins.
  function automatic void model(input int dx, input int dy, output int bin, output bit zero);
    int  ax, ay, mx, mn, mxq, mnq, t, a, th;
    bit  s;
    ax   = (dx < 0) ? -dx : dx;
    ay   = (dy < 0) ? -dy : dy;
    zero = (ax == 0) && (ay == 0);
    bin  = 0;
    if (!zero) begin
      s  = ay > ax;
      mx = s ? ay : ax;
      mn = s ? ax : ay;
      while (mx < (1 << (GW - 1))) begin
        mx = mx * 2;
        mn = mn * 2;
      end
      mxq = mx >> (GW - Q);
      mnq = mn >> (GW - Q);
      t   = $rtoi(real'(F) * $atan(real'(mnq) / real'(mxq)) * 4.0 / M_PI + 0.5);
      a   = s ? (2 * F - t) : t;
      if (dx >= 0 && dy >= 0)     th = a;
      else if (dx < 0 && dy >= 0) th = 4 * F - a;
      else if (dx < 0)            th = 4 * F + a;
      else                        th = 8 * F - a;
      th  = th % (8 * F);
      bin = (th * NBINS + RND) / (8 * F);
      if (bin == NBINS) bin = 0;
    end
  endfunction

  function automatic int pick_val();
    case ($urandom_range(0, 7))
      0:       return -256;
      1:       return 0;
      2:       return 255;
      3:       return int'($urandom_range(0, 6)) - 3;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  // One beat into an idle pipeline; returns the result and its latency.
  task automatic apply_single(input int dx, input int dy, input int tag,
                              output int bin, output bit zero, output int tg, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_dx     = GW'(dx);
    in_dy     = GW'(dy);
    in_tag    = TW'(tag);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    bin  = int'(out_bin);
    zero = out_zero;
    tg   = int'(out_tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_bin !== '0) begin miscompares++; $display("FAIL reset out_bin: got %0d expected 0", out_bin); end
    vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("FAIL reset out_zero: got %0b expected 0", out_zero); end
    vectors++; if (out_tag !== '0) begin miscompares++; $display("FAIL reset out_tag: got %0d expected 0", out_tag); end
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset idle out_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_axes();
    int dxs [4];
    int dys [4];
    int exb [4];
    int bin, tg, lat;
    bit zero;
    dxs = '{10, 0, -10, 0};
    dys = '{0, 10, 0, -10};
    exb = '{0, 9, 18, 27};
    for (int i = 0; i < 4; i++) begin
      apply_single(dxs[i], dys[i], 16 + i, bin, zero, tg, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL axis%0d latency: got %0d expected 4", i, lat); end
      vectors++; if (bin !== exb[i]) begin miscompares++; $display("FAIL axis%0d bin: got %0d expected %0d", i, bin, exb[i]); end
      vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL axis%0d zero: got %0b expected 0", i, zero); end
      vectors++; if (tg !== 16 + i) begin miscompares++; $display("FAIL axis%0d tag: got %0d expected %0d", i, tg, 16 + i); end
    end
  endtask

  task automatic test_diag_and_wrap();
    int bin, tg, lat, exp_diag;
    bit zero;
    exp_diag = RMODE ? 5 : 4;
    apply_single(5, 5, 33, bin, zero, tg, lat);
    vectors++; if (bin !== exp_diag) begin miscompares++; $display("FAIL diag bin: got %0d expected %0d", bin, exp_diag); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL diag latency: got %0d expected 4", lat); end
    apply_single(10, -1, 34, bin, zero, tg, lat);
    vectors++; if (bin !== 35) begin miscompares++; $display("FAIL near_wrap bin: got %0d expected 35", bin); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL near_wrap zero: got %0b expected 0", zero); end
  endtask

  task automatic test_extremes();
    int bin, tg, lat, exp_neg;
    bit zero;
    exp_neg = RMODE ? 23 : 22;
    apply_single(0, 0, 40, bin, zero, tg, lat);
    vectors++; if (bin !== 0) begin miscompares++; $display("FAIL zero_vec bin: got %0d expected 0", bin); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL zero_vec zero: got %0b expected 1", zero); end
    vectors++; if (tg !== 40) begin miscompares++; $display("FAIL zero_vec tag: got %0d expected 40", tg); end
    apply_single(-256, -256, 41, bin, zero, tg, lat);
    vectors++; if (bin !== exp_neg) begin miscompares++; $display("FAIL min_neg bin: got %0d expected %0d", bin, exp_neg); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL min_neg zero: got %0b expected 0", zero); end
    apply_single(-256, 0, 42, bin, zero, tg, lat);
    vectors++; if (bin !== 18) begin miscompares++; $display("FAIL min_neg_x bin: got %0d expected 18", bin); end
  endtask

  task automatic test_back_to_back();
    int   dxs [8];
    int   dys [8];
    int   sent, got, stalls, eb;
    bit   ez, prev_stall;
    logic [OW-1:0] pb;
    logic          pz;
    logic [TW-1:0] pt;
    for (int i = 0; i < 8; i++) begin
      dxs[i] = pick_val();
      dys[i] = pick_val();
    end
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0;
    pb = '0; pz = 1'b0; pt = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_bin !== pb || out_zero !== pz || out_tag !== pt) begin
          miscompares++;
          $display("FAIL b2b hold: got v%0b bin %0d tag %0d expected v1 bin %0d tag %0d", out_valid, out_bin, out_tag, pb, pt);
        end
      end
      out_ready = !(c >= 6 && c <= 8);
      in_valid  = (sent < 8);
      in_dx     = GW'(dxs[sent % 8]);
      in_dy     = GW'(dys[sent % 8]);
      in_tag    = TW'(sent);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b stall in_ready: got %0b expected 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        model(dxs[got], dys[got], eb, ez);
        vectors++; if (out_tag !== TW'(got)) begin miscompares++; $display("FAIL b2b order: got tag %0d expected %0d", out_tag, got); end
        vectors++; if (out_bin !== OW'(eb) || out_zero !== ez) begin miscompares++; $display("FAIL b2b bin: got %0d/%0b expected %0d/%0b", out_bin, out_zero, eb, ez); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      pb = out_bin; pz = out_zero; pt = out_tag;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++; if (got !== 8) begin miscompares++; $display("FAIL b2b count: got %0d expected 8", got); end
    vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL b2b stall cycles: got %0d expected 3", stalls); end
  endtask

  task automatic test_random();
    exp_t exq [$];
    exp_t e;
    int   sent, tag, eb, cyc, dx, dy;
    bit   ez, prev_stall, exp_rdy;
    logic [OW-1:0] pb;
    logic          pz;
    logic [TW-1:0] pt;
    sent = 0; tag = 0; cyc = 0; prev_stall = 1'b0;
    pb = '0; pz = 1'b0; pt = '0;
    while ((sent < 300 || exq.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_bin !== pb || out_zero !== pz || out_tag !== pt) begin
          miscompares++;
          $display("FAIL rand hold: got v%0b bin %0d tag %0d expected v1 bin %0d tag %0d", out_valid, out_bin, out_tag, pb, pt);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      dx = pick_val();
      dy = pick_val();
      in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_dx    = GW'(dx);
      in_dy    = GW'(dy);
      in_tag   = TW'(tag);
      #1;
      exp_rdy = !(out_valid && !out_ready);
      vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL rand in_ready: got %0b expected %0b", in_ready, exp_rdy); end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rand spurious: got tag %0d expected no beat", out_tag);
        end else begin
          e = exq.pop_front();
          vectors++; if (out_tag !== TW'(e.tag)) begin miscompares++; $display("FAIL rand tag: got %0d expected %0d", out_tag, e.tag); end
          vectors++; if (out_bin !== OW'(e.bin) || out_zero !== e.zero) begin miscompares++; $display("FAIL rand bin: got %0d/%0b expected %0d/%0b", out_bin, out_zero, e.bin, e.zero); end
        end
      end
      if (in_valid && in_ready) begin
        model(dx, dy, eb, ez);
        e.bin = eb; e.zero = ez; e.tag = tag;
        exq.push_back(e);
        sent++;
        tag = (tag + 1) % 256;
      end
      prev_stall = out_valid && !out_ready;
      pb = out_bin; pz = out_zero; pt = out_tag;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++; if (exq.size() != 0 || sent != 300) begin miscompares++; $display("FAIL rand drain: got %0d pending %0d sent expected 0 pending 300 sent", exq.size(), sent); end
  endtask

  task automatic test_reset_mid();
    int bin, tg, lat, w, stale;
    bit zero;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_dx    = GW'(0);
      in_dy    = GW'(10);
      in_tag   = TW'(8'hA1 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid fill: got out_valid %0b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid out_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_bin !== '0 || out_zero !== 1'b0) begin miscompares++; $display("FAIL rstmid out_bin: got %0d/%0b expected 0/0", out_bin, out_zero); end
    vectors++; if (out_tag !== '0) begin miscompares++; $display("FAIL rstmid out_tag: got %0d expected 0", out_tag); end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid in_ready: got %0b expected 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    vectors++; if (stale !== 0) begin miscompares++; $display("FAIL rstmid stale: got %0d valid cycles expected 0", stale); end
    apply_single(-10, 0, 8'h55, bin, zero, tg, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rstmid latency: got %0d expected 4", lat); end
    vectors++; if (bin !== 18) begin miscompares++; $display("FAIL rstmid bin: got %0d expected 18", bin); end
    vectors++; if (tg !== 8'h55) begin miscompares++; $display("FAIL rstmid tag: got %0d expected 85", tg); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_axes();
    test_diag_and_wrap();
    test_extremes();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
